// File: rtl/sum_sequencer_if.sv
// Bundle between the sum sequencer and the summing unit / controlling host.
// The master side is the sequencer; the slave side is its environment.
interface sum_sequencer_if;
  logic       start;
  logic [7:0] seed;
  logic       go_l;
  logic [7:0] valueToinA;
  logic       done;
  logic [7:0] sumIn;
  logic [7:0] expSum;
  logic       resultValid;
  logic       match;
  logic       error;
  logic       busy;

  modport master (
    input  start, seed, done, sumIn,
    output go_l, valueToinA, expSum, resultValid, match, error, busy
  );

  modport slave (
    output start, seed, done, sumIn,
    input  go_l, valueToinA, expSum, resultValid, match, error, busy
  );
endinterface

// File: rtl/sum_sequencer.sv
// Drives an LFSR value stream plus zero terminator into a summing unit and
// compares the unit's reported sum against a locally accumulated expected sum.
module sum_sequencer #(
  parameter int NUM_VALUES     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             ck,
  input  logic             reset,
  sum_sequencer_if.master  bus
);

  localparam int CNT_W  = 4;
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_VALUES - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TERM = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t             state_r;
  logic [7:0]         value_r;
  logic [7:0]         exp_sum_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               go_l_r;
  logic               result_valid_r;
  logic               match_r;
  logic               error_r;
  logic               busy_r;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // A zero seed would lock the LFSR, so it is promoted to 8'h01.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge ck) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      value_r        <= 8'h00;
      exp_sum_r      <= 8'h00;
      cnt_r          <= {CNT_W{1'b0}};
      wait_cnt_r     <= WAIT_ZERO;
      go_l_r         <= 1'b1;
      result_valid_r <= 1'b0;
      match_r        <= 1'b0;
      error_r        <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      go_l_r         <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r    <= ST_SEND;
            value_r    <= seed_fix(bus.seed);
            go_l_r     <= 1'b0;
            exp_sum_r  <= 8'h00;
            cnt_r      <= {CNT_W{1'b0}};
            wait_cnt_r <= WAIT_ZERO;
            error_r    <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            value_r    <= 8'h00;
          end
        end
        ST_SEND: begin
          exp_sum_r <= exp_sum_r + value_r;
          if (bus.done) begin
            error_r <= 1'b1;
          end else begin
            error_r <= error_r;
          end
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_TERM;
            value_r <= 8'h00;
          end else begin
            cnt_r   <= cnt_r + 4'd1;
            value_r <= lfsr_next(value_r);
          end
        end
        ST_TERM: begin
          if (bus.done) begin
            error_r <= 1'b1;
          end else begin
            error_r <= error_r;
          end
          state_r    <= ST_WAIT;
          wait_cnt_r <= WAIT_ZERO;
        end
        ST_WAIT: begin
          if (bus.done) begin
            match_r        <= (bus.sumIn == exp_sum_r);
            result_valid_r <= 1'b1;
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
          end else if (wait_cnt_r == LAST_WAIT) begin
            // The unit never answered: report a failed, erroneous run.
            error_r        <= 1'b1;
            match_r        <= 1'b0;
            result_valid_r <= 1'b1;
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
          end else begin
            wait_cnt_r     <= wait_cnt_r + WAIT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          value_r <= 8'h00;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.go_l        = go_l_r;
  assign bus.valueToinA  = value_r;
  assign bus.expSum      = exp_sum_r;
  assign bus.resultValid = result_valid_r;
  assign bus.match       = match_r;
  assign bus.error       = error_r;
  assign bus.busy        = busy_r;

  sum_sequencer_checker u_checker (
    .ck           (ck),
    .reset        (reset),
    .go_l         (go_l_r),
    .value        (value_r),
    .result_valid (result_valid_r),
    .busy         (busy_r)
  );

endmodule

// Output-consistency properties of the sequencer.
module sum_sequencer_checker (
  input logic       ck,
  input logic       reset,
  input logic       go_l,
  input logic [7:0] value,
  input logic       result_valid,
  input logic       busy
);

  go_l_only_when_busy: assert property (@(posedge ck) disable iff (reset)
    (go_l == 1'b0) |-> busy);

  value_only_when_busy: assert property (@(posedge ck) disable iff (reset)
    (value != 8'h00) |-> busy);

  result_only_when_idle: assert property (@(posedge ck) disable iff (reset)
    result_valid |-> !busy);

endmodule

// File: doc/sum_sequencer.md
SUM_SEQUENCER -- requirements
Module: sum_sequencer

Interface
REQ-001 SHALL have parameter NUM_VALUES, default 8, meaning the count of nonzero values sent per run (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles tolerated before an error.
REQ-003 SHALL have port ck  input  1  system clock; the block uses one clock and all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a run; sampled only in IDLE.
REQ-006 SHALL have port seed  input  8  LFSR seed, captured when start is accepted.
REQ-007 SHALL have port go_l  output  1  active-low run-start strobe to the summing unit.
REQ-008 SHALL have port valueToinA  output  8  value stream to the summing unit's inA.
REQ-009 SHALL have port done  input  1  summing unit's completion strobe.
REQ-010 SHALL have port sumIn  input  8  summing unit's sum, valid when done=1.
REQ-011 SHALL have port expSum  output  8  locally computed expected sum.
REQ-012 SHALL have port resultValid  output  1  one-cycle pulse marking the end of a run.
REQ-013 SHALL have port match  output  1  sumIn equalled expSum; valid on resultValid.
REQ-014 SHALL have port error  output  1  sticky protocol or timeout error, cleared on the next accepted start.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, SEND, TERM and WAIT.
REQ-017 IDLE: when start=1 in cycle t, the block SHALL load the LFSR with seed (8'h01 if seed==0), clear expSum, the counter and error, and enter SEND at t+1.
REQ-018 SEND: in cycle t+1+k (k=0..NUM_VALUES-1), valueToinA SHALL equal value v_k and expSum SHALL accumulate v_k.
REQ-019 go_l SHALL be 0 only in the first SEND cycle (k=0) and 1 in every other cycle.
REQ-020 LFSR: v_0 SHALL be the loaded seed, and each next value SHALL be {q[6:0], q[7]^q[5]^q[4]^q[3]}; all values are nonzero.
REQ-021 After v_(NUM_VALUES-1) the block SHALL enter TERM for exactly one cycle with valueToinA=8'h00 (the terminator), then enter WAIT.
REQ-022 expSum SHALL be the sum of all v_k modulo 256 (8-bit wrap, carry discarded) and SHALL hold its value until the next accepted start.
REQ-023 WAIT: on the cycle done=1, the block SHALL register match=(sumIn==expSum), pulse resultValid for 1 cycle the next cycle, and return to IDLE in that same cycle.
REQ-024 WAIT timeout: if done stays 0 for TIMEOUT_CYCLES consecutive WAIT cycles, the block SHALL set error=1 and match=0, pulse resultValid, and go to IDLE.
REQ-025 If done=1 in SEND or TERM, the block SHALL set error=1 and otherwise continue the sequence unchanged.
REQ-026 A done=1 in IDLE SHALL be ignored.
REQ-027 start while busy=1 SHALL be ignored; it is neither queued nor allowed to disturb the run.
REQ-028 If start=1 in the same cycle as the resultValid pulse, the start SHALL be accepted because the state is IDLE.
REQ-029 valueToinA SHALL be 8'h00 in IDLE, TERM and WAIT.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL force state IDLE and set go_l=1, valueToinA=0, expSum=0, resultValid=0, match=0, error=0, busy=0 and the counters to 0.
REQ-031 Reset SHALL override start in the same cycle.
REQ-032 Reset mid-run SHALL abort the run with no resultValid pulse, and go_l SHALL never be driven low during reset.

Verification
REQ-033 Seed 8'h01, NUM_VALUES=3, done with sumIn=8'h07 two cycles after TERM -> valueToinA 01,02,04,00; go_l low only with 01; expSum=07; resultValid pulse with match=1, error=0.
REQ-034 Seed 8'hFF, NUM_VALUES=2, sumIn=8'hFD -> values FF,FE; expSum=FD (wrapped); match=1. Repeat with sumIn=8'h1F -> match=0.
REQ-035 Seed 8'h00 -> first value 8'h01, identical to the seed-01 run.
REQ-036 No done, TIMEOUT_CYCLES=64 -> resultValid exactly 64 cycles after entering WAIT; error=1, match=0; busy=0 afterwards.
REQ-037 Reset asserted in the second SEND cycle -> next cycle all outputs at reset values and no resultValid; a fresh start then runs normally from v_0.
REQ-038 start held high through a whole run, and done pulsed during SEND -> second start not accepted until IDLE; error=1 at resultValid; error cleared by the next accepted start.
